// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential MixColumns stage.
// master drives the input side and consumes results; slave is the stage.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid,
    output state_in,
    output bypass,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  state_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  state_in,
    input  bypass,
    input  out_ready,
    output in_ready,
    output out_valid,
    output state_out,
    output busy
  );
endinterface

// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns, one 32-bit column per cycle.
// Final-round blocks bypass the mixer and go straight to the output register.
module mix_columns_seq #(
  parameter bit INVERSE = 1'b0
) (
  input logic              clk,
  input logic              rst,
  mix_columns_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   col_cnt_q;
  logic [127:0] st_q;
  logic [127:0] state_out_q;
  logic         out_valid_q;
  logic [31:0]  col_in;
  logic [31:0]  col_mix;

  function automatic logic [7:0] xt(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Constant coefficients fold this down to a few xors.
  function automatic logic [7:0] gmul(
    input logic [7:0] x,
    input logic [3:0] c
  );
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return ({8{c[0]}} & x)
         ^ ({8{c[1]}} & x2)
         ^ ({8{c[2]}} & x4)
         ^ ({8{c[3]}} & x8);
  endfunction

  // Output row r takes coefficient k[(j-r) mod 4] for input row j.
  function automatic logic [31:0] mix(
    input logic [31:0] a
  );
    logic [3:0]  k [4];
    logic [7:0]  ab [4];
    logic [7:0]  acc;
    logic [1:0]  idx;
    logic [31:0] b;
    if (INVERSE) begin
      k = '{4'hE, 4'hB, 4'hD, 4'h9};
    end else begin
      k = '{4'h2, 4'h3, 4'h1, 4'h1};
    end
    for (int i = 0; i < 4; i++) begin
      ab[i] = a[31-8*i -: 8];
    end
    b = '0;
    for (int r = 0; r < 4; r++) begin
      acc = '0;
      for (int j = 0; j < 4; j++) begin
        idx = 2'(j - r);
        acc = acc ^ gmul(ab[j], k[idx]);
      end
      b[31-8*r -: 8] = acc;
    end
    return b;
  endfunction

  always_comb begin
    col_in = st_q[127:96];
    unique case (col_cnt_q)
      2'd0: col_in = st_q[127:96];
      2'd1: col_in = st_q[95:64];
      2'd2: col_in = st_q[63:32];
      2'd3: col_in = st_q[31:0];
      default: col_in = st_q[127:96];
    endcase
  end

  assign col_mix = mix(col_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = bus.bypass ? DONE : CALC;
        end
      end
      CALC: begin
        if (col_cnt_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q   <= '0;
      st_q        <= '0;
      state_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            st_q      <= bus.state_in;
            col_cnt_q <= '0;
          end
        end
        CALC: begin
          unique case (col_cnt_q)
            2'd0: st_q[127:96] <= col_mix;
            2'd1: st_q[95:64]  <= col_mix;
            2'd2: st_q[63:32]  <= col_mix;
            2'd3: st_q[31:0]   <= col_mix;
            default: st_q <= st_q;
          endcase
          col_cnt_q <= col_cnt_q + 2'd1;
        end
        DONE: begin
          // First DONE cycle loads the result; later cycles wait for ready.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            state_out_q <= st_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.state_out = state_out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq, forward and inverse builds side by side.
// Both DUTs see identical stimulus; each step checks the build it targets.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         bypass = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] state_in = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mix_columns_seq_if fw ();
  mix_columns_seq_if iv ();

  assign fw.in_valid  = in_valid;
  assign fw.state_in  = state_in;
  assign fw.bypass    = bypass;
  assign fw.out_ready = out_ready;
  assign iv.in_valid  = in_valid;
  assign iv.state_in  = state_in;
  assign iv.bypass    = bypass;
  assign iv.out_ready = out_ready;

  mix_columns_seq #(.INVERSE(1'b0)) u_fwd (
    .clk (clk),
    .rst (rst),
    .bus (fw.slave)
  );

  mix_columns_seq #(.INVERSE(1'b1)) u_inv (
    .clk (clk),
    .rst (rst),
    .bus (iv.slave)
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [127:0] d,
    input logic         b,
    input int           exp_lat,
    input string        tag
  );
    int n;
    state_in = d;
    bypass   = b;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, 128'(fw.in_ready), 128'(1));
    tick;
    in_valid = 1'b0;
    bypass   = 1'b0;
    n = 0;
    while (!fw.out_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, 128'(n), 128'(exp_lat));
  endtask

  task automatic drain_out(
    input string tag
  );
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 128'(fw.out_valid), 128'(0));
    chk({tag, "_in_ready_back"}, 128'(fw.in_ready), 128'(1));
  endtask

  localparam logic [127:0] V1_IN  = {4{32'hDB135345}};
  localparam logic [127:0] V1_OUT = {4{32'h8E4DA1BC}};
  localparam logic [127:0] V2_IN  =
    {32'hDB135345, 32'hF20A225C, 32'h01010101, 32'hC6C6C6C6};
  localparam logic [127:0] V2_OUT =
    {32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101, 32'hC6C6C6C6};
  localparam logic [127:0] V3_IN  =
    {32'hD4D4D4D5, 32'h2D26314C, 32'hDB135345, 32'hF20A225C};
  localparam logic [127:0] V3_OUT =
    {32'hD5D5D7D6, 32'h4D7EBDF8, 32'h8E4DA1BC, 32'h9FDC589D};
  localparam logic [127:0] BYP    =
    128'h00112233445566778899AABBCCDDEEFF;

  initial begin
    tick;
    tick;
    chk("rst_out_valid", 128'(fw.out_valid), 128'(0));
    chk("rst_state_out", fw.state_out, '0);
    chk("rst_in_ready_low", 128'(fw.in_ready), 128'(0));
    chk("rst_busy", 128'(fw.busy), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(fw.in_ready), 128'(1));

    send(V1_IN, 1'b0, 5, "v1");
    chk("v1_state_out", fw.state_out, V1_OUT);
    chk("v1_busy", 128'(fw.busy), 128'(1));
    drain_out("v1");

    send(V2_IN, 1'b0, 5, "v2");
    chk("v2_state_out", fw.state_out, V2_OUT);
    drain_out("v2");

    send(V3_IN, 1'b0, 5, "v3");
    chk("v3_state_out", fw.state_out, V3_OUT);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_out_valid", 128'(fw.out_valid), 128'(1));
      chk("bp_state_out", fw.state_out, V3_OUT);
      chk("bp_in_ready", 128'(fw.in_ready), 128'(0));
    end
    drain_out("bp");

    send(BYP, 1'b1, 1, "byp");
    chk("byp_state_out", fw.state_out, BYP);
    drain_out("byp");

    // Reset lands while column 2 is being mixed.
    state_in = V1_IN;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    chk("mid_busy", 128'(fw.busy), 128'(1));
    rst = 1'b1;
    tick;
    chk("mid_rst_out_valid", 128'(fw.out_valid), 128'(0));
    chk("mid_rst_state_out", fw.state_out, '0);
    chk("mid_rst_in_ready", 128'(fw.in_ready), 128'(0));
    chk("mid_rst_busy", 128'(fw.busy), 128'(0));
    rst = 1'b0;
    #1;
    chk("mid_rst_in_ready_up", 128'(fw.in_ready), 128'(1));

    send(V1_OUT, 1'b0, 5, "inv1");
    chk("inv1_out_valid", 128'(iv.out_valid), 128'(1));
    chk("inv1_state_out", iv.state_out, V1_IN);
    drain_out("inv1");

    send({4{32'h9FDC589D}}, 1'b0, 5, "inv2");
    chk("inv2_state_out", iv.state_out, {4{32'hF20A225C}});
    drain_out("inv2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
